// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline stage state encoding and default bubble PC
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    localparam logic [31:0] BUBBLE_PC_DEF = 32'h0000_3008;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: PC+data holding register with load and clear-to-bubble
// ports: clk, rst_n (sync, active-low), clr (force bubble), ld (capture d_*),
//        d_pc/d_data in, q_pc/q_data out
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int PCW = 32,
    parameter int DW = 32,
    parameter logic [PCW-1:0] BUBBLE_PC = PCW'(BUBBLE_PC_DEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           ld,
    input  logic [PCW-1:0] d_pc,
    input  logic [DW-1:0]  d_data,
    output logic [PCW-1:0] q_pc,
    output logic [DW-1:0]  q_data
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            q_pc   <= BUBBLE_PC;
            q_data <= '0;
        end else if (ld) begin
            q_pc   <= d_pc;
            q_data <= d_data;
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with two-entry skid buffer and flush
// ports: clk, rst_n (sync, active-low); upstream in_valid/in_ready/in_pc/in_data;
//        flush; downstream out_valid/out_ready/out_pc/out_data; stall_cnt
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int PCW = 32,
    parameter logic [PCW-1:0] BUBBLE_PC = PCW'(BUBBLE_PC_DEF),
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [PCW-1:0] in_pc,
    input  logic [DW-1:0]  in_data,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PCW-1:0] out_pc,
    output logic [DW-1:0]  out_data,
    output logic [CW-1:0]  stall_cnt
);
    state_t state, state_nx;
    logic accept, emit, main_ld, skid_ld;
    logic [PCW-1:0] skid_pc, main_d_pc;
    logic [DW-1:0] skid_data, main_d_data;

    // both handshake outputs decode the state flop only, so they are registered
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_nx = flush ? EMPTY :
                   state == EMPTY ? (accept ? ONE : EMPTY) :
                   state == ONE   ? (accept && !emit ? FULL : !accept && emit ? EMPTY : ONE) :
                                    (emit ? ONE : FULL);
        main_ld  = !flush && (state == FULL ? emit : accept && (state == EMPTY || emit));
        skid_ld  = !flush && state == ONE && accept && !emit;
        // draining FULL promotes the skid beat into the main slot
        main_d_pc   = state == FULL ? skid_pc : in_pc;
        main_d_data = state == FULL ? skid_data : in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + CW'(1);
    end

    pipe_slot #(.PCW(PCW), .DW(DW), .BUBBLE_PC(BUBBLE_PC)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(flush), .ld(main_ld),
        .d_pc(main_d_pc), .d_data(main_d_data), .q_pc(out_pc), .q_data(out_data)
    );

    pipe_slot #(.PCW(PCW), .DW(DW), .BUBBLE_PC(BUBBLE_PC)) u_skid (
        .clk(clk), .rst_n(rst_n), .clr(flush), .ld(skid_ld),
        .d_pc(in_pc), .d_data(in_data), .q_pc(skid_pc), .q_data(skid_data)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks against a queue-based model
module tb_pipe_stage_skid;
    localparam logic [31:0] BUB = 32'h0000_3008;
    localparam int CMAX = 15;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } beat_t;

    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [31:0] in_pc = 0;
    logic [31:0] in_data = 0;
    logic flush = 0;
    logic out_valid;
    logic out_ready = 0;
    logic [31:0] out_pc;
    logic [31:0] out_data;
    logic [3:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    bit do_check = 0;

    beat_t q[$];
    beat_t last;
    int cnt = 0;
    int saved_cnt;

    pipe_stage_skid #(.DW(32), .PCW(32), .BUBBLE_PC(BUB), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // model: up to two beats queued; front is shown, otherwise the last shown value lingers
    task automatic check_all();
        beat_t shown;
        shown = q.size() > 0 ? q[0] : last;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_pc", out_pc, shown.pc);
        chk("out_data", out_data, shown.data);
        chk("stall_cnt", 32'(stall_cnt), 32'(cnt));
    endtask

    task automatic model_edge();
        bit em, ac;
        if (!rst_n) begin
            q.delete();
            last = '{BUB, 32'h0};
            cnt = 0;
        end else begin
            em = q.size() > 0 && out_ready;
            ac = in_valid && q.size() < 2;
            if (q.size() > 0 && !out_ready && cnt < CMAX) cnt++;
            if (flush) begin
                q.delete();
                last = '{BUB, 32'h0};
            end else begin
                if (em) last = q.pop_front();
                if (ac) q.push_back('{in_pc, in_data});
            end
        end
    endtask

    task automatic tick();
        if (do_check) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1;
        in_pc = pc;
        in_data = $urandom;
    endtask

    initial begin
        last = '{BUB, 32'h0};
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_pc", out_pc, 32'h3008);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        do_check = 1;

        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            offer(32'h3000 + 32'(i * 4));
            tick();
        end
        in_valid = 0;
        tick();
        tick();

        out_ready = 0;
        offer(32'h3000);
        tick();
        offer(32'h3004);
        tick();
        in_valid = 0;
        chk("fill_in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        out_ready = 1;
        tick();
        chk("drain_in_ready", 32'(in_ready), 32'h1);
        tick();
        tick();

        out_ready = 0;
        offer(32'h3100);
        tick();
        offer(32'h3104);
        tick();
        out_ready = 1;
        offer(32'h3008);
        flush = 1;
        saved_cnt = cnt;
        tick();
        flush = 0;
        in_valid = 0;
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_out_pc", out_pc, 32'h3008);
        chk("flush_out_data", out_data, 32'h0);
        chk("flush_stall_cnt", 32'(stall_cnt), 32'(saved_cnt));
        for (int i = 0; i < 3; i++) tick();

        offer(32'h3200);
        tick();
        in_valid = 0;
        out_ready = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_pc = $urandom;
            in_data = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            rst_n = $urandom_range(0, 63) != 0;
            tick();
        end
        rst_n = 1;
        flush = 0;
        in_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
